snoop_bus_arbiter: RTL and testbench
====================================

# snoop_bus_arbiter

Shared-bus controller for the cache-coherence subsystem. Each per-line cache controller raises read-miss, write-miss and write-back requests. This block grants the bus round-robin, performs the write-back to memory, then broadcasts the read-miss or write-miss snoop to every other cache and performs the memory fill. It ends each transaction with an acknowledge pulse back to the requester.

## Interface
- NUM_CACHES, 4, number of attached cache controllers (≥2)
- MEM_LATENCY, 4, cycles per memory read or write beat (≥1)

- clk  input  1  bus clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- req_rd_miss  input  NUM_CACHES  per-cache read-miss request; level, held until ack
- req_wr_miss  input  NUM_CACHES  per-cache write-miss request; level, held until ack
- req_wb  input  NUM_CACHES  per-cache write-back request; level, held until ack; may accompany a miss
- snoop_rd_miss  output  NUM_CACHES  one-cycle read-miss broadcast to all caches except the owner
- snoop_wr_miss  output  NUM_CACHES  one-cycle write-miss broadcast to all caches except the owner
- ack  output  NUM_CACHES  one-hot, one-cycle completion pulse to the owner
- mem_rd  output  1  memory fill in progress
- mem_wr  output  1  memory write-back in progress
- bus_busy  output  1  high in every state except IDLE
- bus_owner  output  $clog2(NUM_CACHES)  index of the current owner; holds its last value while idle

## Operation
- States: IDLE, WB, SNOOP, FILL, DONE. All outputs are decoded from registered state and the latched owner and type (Moore).
- IDLE:
  - A cache is "requesting" if any of its three request bits is high.
  - If no cache is requesting, stay in IDLE.
  - Otherwise select the first requesting cache searching upward from last_grant+1, with wrap-around modulo NUM_CACHES.
  - Latch owner index, wb flag and miss type. Write miss dominates if rd and wr miss are both high.
  - Next state is WB if wb is set, otherwise SNOOP.
- WB: mem_wr=1 for MEM_LATENCY cycles. Then go to SNOOP if a miss is latched, otherwise to DONE.
- SNOOP: one cycle.
  - snoop_rd_miss or snoop_wr_miss equals all-ones with the owner bit cleared.
  - The other snoop vector is 0.
  - Next state is FILL.
- FILL: mem_rd=1 for MEM_LATENCY cycles, then go to DONE.
- DONE: one cycle.
  - ack has only the owner bit high.
  - last_grant is updated to the owner index.
  - Next state is IDLE.
- Latency counter:
  - Width $clog2(MEM_LATENCY+1).
  - Loaded with MEM_LATENCY-1 on entry to WB or FILL, and decrements each cycle.
  - The state exits when the counter is 0.
- Requests are sampled only in IDLE. Request changes during other states are ignored.
- Write-backs that snooped caches raise in response to a broadcast are ordinary requests for later arbitration. The block does not preempt or merge transactions.
- Request bit patterns with no rd or wr miss and no wb are never "requesting".

## Timing
- Reset state:
  - State IDLE, last_grant=NUM_CACHES-1 (cache 0 has first priority), counter 0.
  - All outputs 0, including bus_owner.
- Reset mid-transaction: the next cycle is IDLE with all outputs 0. No ack is issued for the aborted transaction, and the requester keeps its request asserted.
- Take request sampled in IDLE at cycle t as the reference. With L=MEM_LATENCY:
  - Miss only: SNOOP at t+1, mem_rd t+2..t+L+1, ack at t+L+2.
  - Wb+miss: mem_wr t+1..t+L, SNOOP at t+L+1, mem_rd t+L+2..t+2L+1, ack at t+2L+2.
  - Wb only: mem_wr t+1..t+L, ack at t+L+1.
- Handshake: the requester clears its request bits on the edge at which it samples ack=1. The following IDLE cycle therefore sees the updated requests.
- Back-to-back transactions: one IDLE cycle separates DONE from the next grant. A miss-only transaction occupies L+3 cycles.
- mem_rd and mem_wr are never high simultaneously. At most one of snoop_rd_miss or snoop_wr_miss is nonzero in any cycle.

## Test plan
- NUM_CACHES=4, MEM_LATENCY=4 for all scenarios. Each row gives stimulus -> required response.
- Read miss: req_rd_miss=0010 at cycle 0 -> bus_owner=1, snoop_rd_miss=1101 at cycle 1, mem_rd cycles 2–5, ack=0010 at cycle 6, bus_busy low at cycle 7.
- Write miss with write-back: cache 2 drives req_wr_miss and req_wb -> mem_wr cycles 1–4, snoop_wr_miss=1011 at cycle 5, mem_rd cycles 6–9, ack=0100 at cycle 10.
- Write-back only: req_wb=1000 -> mem_wr cycles 1–4, ack=1000 at cycle 5, snoop vectors and mem_rd stay 0 throughout.
- Round-robin: req_rd_miss=1111 after reset, each bit cleared on its ack -> grants 0,1,2,3 in order, acks 0001, 0010, 0100, 1000 at cycles 6, 13, 20, 27.
- Conflict: cache 0 drives both req_rd_miss and req_wr_miss -> snoop_wr_miss=1110, snoop_rd_miss=0000.
- Reset mid-operation: rst high during cycle 3 of the read-miss case -> all outputs 0 the next cycle and no ack. After release, with req_rd_miss=0010 still held, the transaction reruns with ack 6 cycles after the first IDLE.

Source files
------------

// File: rtl/snoop_bus_arbiter.sv
// Round-robin shared-bus controller for the snooping cache-coherence fabric.
// Sequences write-back, miss broadcast, memory fill and a one-cycle ack per transaction.
module snoop_bus_arbiter #(
  parameter int NUM_CACHES  = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CACHES-1:0]         req_rd_miss,
  input  logic [NUM_CACHES-1:0]         req_wr_miss,
  input  logic [NUM_CACHES-1:0]         req_wb,
  output logic [NUM_CACHES-1:0]         snoop_rd_miss,
  output logic [NUM_CACHES-1:0]         snoop_wr_miss,
  output logic [NUM_CACHES-1:0]         ack,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic                          bus_busy,
  output logic [$clog2(NUM_CACHES)-1:0] bus_owner
);

  localparam int IW = $clog2(NUM_CACHES);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WB, SNOOP, FILL, DONE} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   owner_reg, owner_next;
  logic [IW-1:0]   last_grant_reg, last_grant_next;
  logic            miss_reg, miss_next;
  logic            wr_reg, wr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic [NUM_CACHES-1:0] requesting;
  logic [NUM_CACHES-1:0] owner_mask;
  logic [IW-1:0]         pick;
  logic                  found;
  int                    idx;

  assign requesting = req_rd_miss | req_wr_miss | req_wb;
  assign owner_mask = NUM_CACHES'(1) << owner_reg;

  // Search upward from the cache after the last grant, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_CACHES; i++) begin
      idx = (int'(last_grant_reg) + i) % NUM_CACHES;
      if (!found && requesting[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_grant_reg <= IW'(NUM_CACHES - 1);
      miss_reg       <= 1'b0;
      wr_reg         <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      miss_reg       <= miss_next;
      wr_reg         <= wr_next;
      cnt_reg        <= cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    miss_next       = miss_reg;
    wr_next         = wr_reg;
    cnt_next        = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          owner_next = pick;
          miss_next  = req_rd_miss[pick] | req_wr_miss[pick];
          wr_next    = req_wr_miss[pick];
          if (req_wb[pick]) begin
            state_next = WB;
            cnt_next   = CNT_LOAD;
          end else begin
            state_next = SNOOP;
          end
        end
      end
      WB: begin
        if (cnt_reg == '0) begin
          state_next = miss_reg ? SNOOP : DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      SNOOP: begin
        state_next = FILL;
        cnt_next   = CNT_LOAD;
      end
      FILL: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        last_grant_next = owner_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs: decoded purely from registered state and latched owner/type.
  always_comb begin
    snoop_rd_miss = '0;
    snoop_wr_miss = '0;
    ack           = '0;
    mem_rd        = (state_reg == FILL);
    mem_wr        = (state_reg == WB);
    bus_busy      = (state_reg != IDLE);
    bus_owner     = owner_reg;
    if (state_reg == SNOOP) begin
      if (wr_reg) snoop_wr_miss = ~owner_mask;
      else        snoop_rd_miss = ~owner_mask;
    end
    if (state_reg == DONE) ack = owner_mask;
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: directed vector table, hand sequences for
// round-robin and mid-transaction reset, and random traffic against a schedule model.
module tb_snoop_bus_arbiter;
  localparam int N = 4;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] rd, wr, wb;
  logic [N-1:0] snoop_rd_miss, snoop_wr_miss, ack;
  logic         mem_rd, mem_wr, bus_busy;
  logic [1:0]   bus_owner;

  int checks = 0;
  int failures = 0;

  snoop_bus_arbiter #(.NUM_CACHES(N), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_rd_miss(rd), .req_wr_miss(wr), .req_wb(wb),
    .snoop_rd_miss(snoop_rd_miss), .snoop_wr_miss(snoop_wr_miss), .ack(ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .bus_busy(bus_busy), .bus_owner(bus_owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         busy;
    logic [1:0]   owner;
    logic         mrd;
    logic         mwr;
    logic [N-1:0] srd;
    logic [N-1:0] swr;
    logic [N-1:0] ack;
  } obs_t;

  typedef struct {
    logic [N-1:0] rd, wr, wb;
    int           owner;
    int           ack_cyc;
    logic [N-1:0] ack_val;
    logic [N-1:0] srd, swr;
    int           snoop_cyc;
    int           nrd, nwr;
  } vec_t;

  function automatic obs_t observe();
    obs_t o;
    o.busy  = bus_busy;
    o.owner = bus_owner;
    o.mrd   = mem_rd;
    o.mwr   = mem_wr;
    o.srd   = snoop_rd_miss;
    o.swr   = snoop_wr_miss;
    o.ack   = ack;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0: first IDLE cycle after reset, inputs may be driven.
  task automatic do_reset();
    rst = 1'b1; rd = '0; wr = '0; wb = '0;
    step();
    check("reset_outputs", 32'(observe()), 32'(obs_t'('0)));
    step();
    rst = 1'b0;
  endtask

  // ---------------- reference schedule model ----------------
  obs_t q[$];
  int   model_last;
  logic [1:0] model_owner;

  task automatic model_grant(input int o, input logic m_rd, input logic m_wr, input logic m_wb);
    obs_t r;
    logic [N-1:0] one;
    one = 1;
    r = '0; r.busy = 1'b1; r.owner = 2'(o);
    if (m_wb) begin
      r.mwr = 1'b1;
      repeat (L) q.push_back(r);
      r.mwr = 1'b0;
    end
    if (m_rd || m_wr) begin
      if (m_wr) r.swr = ~(one << o);
      else      r.srd = ~(one << o);
      q.push_back(r);
      r.srd = '0; r.swr = '0; r.mrd = 1'b1;
      repeat (L) q.push_back(r);
      r.mrd = 1'b0;
    end
    r.ack = one << o;
    q.push_back(r);
    model_last  = o;
    model_owner = 2'(o);
  endtask

  task automatic model_cycle();
    obs_t r;
    int c;
    if (q.size() == 0) begin
      r = '0; r.owner = model_owner;
      q.push_back(r);
      for (int i = 1; i <= N; i++) begin
        c = (model_last + i) % N;
        if (rd[c] || wr[c] || wb[c]) begin
          model_grant(c, rd[c], wr[c], wb[c]);
          break;
        end
      end
    end
  endtask

  vec_t tbl[4];

  initial begin
    obs_t o, e;
    int ack_cyc, snoop_cyc, nrd, nwr;
    logic [N-1:0] ack_val, srd_acc, swr_acc, clr;
    int acyc[$];
    logic [N-1:0] aval[$];

    tbl[0] = '{rd:4'b0010, wr:4'b0000, wb:4'b0000, owner:1, ack_cyc:6,  ack_val:4'b0010,
               srd:4'b1101, swr:4'b0000, snoop_cyc:1, nrd:4, nwr:0};
    tbl[1] = '{rd:4'b0000, wr:4'b0100, wb:4'b0100, owner:2, ack_cyc:10, ack_val:4'b0100,
               srd:4'b0000, swr:4'b1011, snoop_cyc:5, nrd:4, nwr:4};
    tbl[2] = '{rd:4'b0000, wr:4'b0000, wb:4'b1000, owner:3, ack_cyc:5,  ack_val:4'b1000,
               srd:4'b0000, swr:4'b0000, snoop_cyc:-1, nrd:0, nwr:4};
    tbl[3] = '{rd:4'b0001, wr:4'b0001, wb:4'b0000, owner:0, ack_cyc:6,  ack_val:4'b0001,
               srd:4'b0000, swr:4'b1110, snoop_cyc:1, nrd:4, nwr:0};

    // ---------------- directed vector table ----------------
    for (int v = 0; v < 4; v++) begin
      do_reset();
      rd = tbl[v].rd; wr = tbl[v].wr; wb = tbl[v].wb;
      ack_cyc = -1; snoop_cyc = -1; nrd = 0; nwr = 0;
      ack_val = '0; srd_acc = '0; swr_acc = '0;
      for (int cyc = 1; cyc <= 14; cyc++) begin
        step();
        if (ack_cyc >= 0 && cyc == ack_cyc + 1) begin
          rd = '0; wr = '0; wb = '0;
        end
        o = observe();
        if (cyc == 1) check($sformatf("v%0d_owner", v), 32'(o.owner), 32'(tbl[v].owner));
        if (o.ack != '0 && ack_cyc < 0) begin ack_cyc = cyc; ack_val = o.ack; end
        if ((o.srd | o.swr) != '0 && snoop_cyc < 0) snoop_cyc = cyc;
        srd_acc |= o.srd; swr_acc |= o.swr;
        if (o.mrd) nrd++;
        if (o.mwr) nwr++;
        if (o.mrd && o.mwr) check($sformatf("v%0d_mem_overlap", v), 32'(cyc), 32'(0));
        if (ack_cyc >= 0 && cyc == ack_cyc + 1)
          check($sformatf("v%0d_busy_after_ack", v), 32'(o.busy), 32'(0));
      end
      check($sformatf("v%0d_ack_cycle", v), 32'(ack_cyc), 32'(tbl[v].ack_cyc));
      check($sformatf("v%0d_ack_value", v), 32'(ack_val), 32'(tbl[v].ack_val));
      check($sformatf("v%0d_snoop_cycle", v), 32'(snoop_cyc), 32'(tbl[v].snoop_cyc));
      check($sformatf("v%0d_snoop_rd", v), 32'(srd_acc), 32'(tbl[v].srd));
      check($sformatf("v%0d_snoop_wr", v), 32'(swr_acc), 32'(tbl[v].swr));
      check($sformatf("v%0d_mem_rd_cycles", v), 32'(nrd), 32'(tbl[v].nrd));
      check($sformatf("v%0d_mem_wr_cycles", v), 32'(nwr), 32'(tbl[v].nwr));
      $display("vector %0d: ack at cycle %0d value %b", v, ack_cyc, ack_val);
    end

    // ---------------- round-robin ----------------
    do_reset();
    rd = 4'b1111;
    clr = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      step();
      rd &= ~clr; clr = '0;
      o = observe();
      if (o.ack != '0) begin acyc.push_back(cyc); aval.push_back(o.ack); clr = o.ack; end
    end
    check("rr_ack_count", 32'(acyc.size()), 32'(4));
    for (int k = 0; k < 4 && k < acyc.size(); k++) begin
      check($sformatf("rr_ack%0d_cycle", k), 32'(acyc[k]), 32'(6 + 7 * k));
      check($sformatf("rr_ack%0d_value", k), 32'(aval[k]), 32'(1 << k));
      $display("round-robin grant %0d: ack at cycle %0d value %b", k, acyc[k], aval[k]);
    end

    // ---------------- reset mid-transaction ----------------
    do_reset();
    rd = 4'b0010;
    ack_cyc = -1; ack_val = '0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      step();
      if (cyc == 3) rst = 1'b1;
      if (cyc == 4) begin
        check("midreset_outputs", 32'(observe()), 32'(obs_t'('0)));
        rst = 1'b0;
      end
      o = observe();
      if (o.ack != '0 && ack_cyc < 0) begin ack_cyc = cyc; ack_val = o.ack; end
    end
    check("midreset_ack_cycle", 32'(ack_cyc), 32'(10));
    check("midreset_ack_value", 32'(ack_val), 32'(4'b0010));
    $display("mid-reset rerun: ack at cycle %0d value %b", ack_cyc, ack_val);
    rd = '0;

    // ---------------- random traffic vs schedule model ----------------
    do_reset();
    q.delete();
    model_last = N - 1;
    model_owner = '0;
    clr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rd &= ~clr; wr &= ~clr; wb &= ~clr; clr = '0;
      for (int i = 0; i < N; i++) begin
        if (!(rd[i] || wr[i] || wb[i]) && $urandom_range(0, 3) == 0) begin
          logic [2:0] pat;
          pat = 3'($urandom_range(1, 7));
          rd[i] = pat[0]; wr[i] = pat[1]; wb[i] = pat[2];
        end
      end
      model_cycle();
      e = q.pop_front();
      o = observe();
      if (e.ack != '0)
        $display("random txn: cycle %0d owner %0d ack %b", cyc, e.owner, o.ack);
      check($sformatf("random_cycle%0d", cyc), 32'(o), 32'(e));
      clr = e.ack;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
